// File: rtl/rgmii_rx_frame_parser.sv
// RGMII receive frame parser: preamble/SFD strip, byte assembly, framed output with good/bad counters.
// Define RGMII_RX_FCS_CHECK_EN to add CRC-32 FCS checking on every frame.
module rgmii_rx_frame_parser #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MIN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             I_rst_n,
    input  logic             i_speed_sel,
    input  logic [7:0]       i_rxd,
    input  logic             i_rxdv,
    input  logic             i_rxer,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_err,
    output logic [CNT_W-1:0] o_good_cnt,
    output logic [CNT_W-1:0] o_bad_cnt
);

    // Handshake: o_valid is a one-cycle strobe with no back-pressure; o_sof/o_eof/o_err
    // are meaningful only while o_valid=1, and o_err only together with o_eof.

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    localparam logic [7:0] PRE_THR_G = 8'(PRE_MIN);
    localparam logic [7:0] PRE_THR_N = 8'(2 * PRE_MIN);

    state_t           state_q, state_d;
    logic             speed_q;
    logic [7:0]       pre_cnt_q;
    logic [3:0]       nib_lo_q;
    logic             half_q;
    logic [7:0]       hold_q;
    logic             hold_vld_q;
    logic             first_q;
    logic [CNT_W-1:0] len_q;
    logic             err_q;

    logic             speed;
    logic             is_pre;
    logic             is_sfd;
    logic             pre_ok;
    logic             byte_done;
    logic [7:0]       byte_val;
    logic             oversize;
    logic             short_frm;
    logic             crc_bad;
    logic             emit;
    logic             emit_eof;
    logic             emit_err;
    logic             zero_len;
    logic             good_inc;
    logic             bad_inc;

    // In IDLE the live speed select decides how the very first symbol is read.
    assign speed     = (state_q == S_IDLE) ? i_speed_sel : speed_q;
    assign is_pre    = speed ? (i_rxd == 8'h55) : (i_rxd[3:0] == 4'h5);
    assign is_sfd    = speed ? (i_rxd == 8'hD5) : (i_rxd[3:0] == 4'hD);
    assign pre_ok    = speed ? (pre_cnt_q >= PRE_THR_G) : (pre_cnt_q >= PRE_THR_N);
    assign oversize  = byte_done && (len_q == CNT_W'(MAX_LEN));
    assign short_frm = (len_q < CNT_W'(MIN_LEN));
    assign good_inc  = emit && emit_eof && !emit_err;
    assign bad_inc   = (emit && emit_eof && emit_err) || zero_len;

    always_comb begin
        byte_done = 1'b0;
        byte_val  = 8'h00;
        if (state_q == S_DATA && i_rxdv) begin
            if (speed_q) begin
                byte_done = 1'b1;
                byte_val  = i_rxd;
            end else if (half_q) begin
                byte_done = 1'b1;
                byte_val  = {i_rxd[3:0], nib_lo_q};
            end
        end
    end

`ifdef RGMII_RX_FCS_CHECK_EN
    // Reflected CRC register; 0xDEBB20E3 is the bit-reversed form of residue 0xC704DD7B.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    logic [31:0] crc_q;
    logic [31:0] crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_next = crc_byte(crc_q, byte_val);
    assign crc_bad  = (crc_q != CRC_RESIDUE);

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (state_q != S_DATA) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (byte_done) begin
            crc_q <= crc_next;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_eof = 1'b0;
        emit_err = 1'b0;
        zero_len = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rxdv) state_d = is_pre ? S_PRE : S_DROP;
            end
            S_PRE: begin
                if (!i_rxdv)               state_d = S_IDLE;
                else if (is_pre)           state_d = S_PRE;
                else if (is_sfd && pre_ok) state_d = S_DATA;
                else                       state_d = S_DROP;
            end
            S_DATA: begin
                if (!i_rxdv) begin
                    state_d = S_IDLE;
                    if (hold_vld_q) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                        emit_err = err_q || short_frm || half_q || crc_bad;
                    end else begin
                        zero_len = 1'b1;
                    end
                end else if (byte_done) begin
                    emit = hold_vld_q;
                    if (oversize) begin
                        state_d  = S_DROP;
                        emit_eof = 1'b1;
                        emit_err = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!i_rxdv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            speed_q    <= 1'b0;
            pre_cnt_q  <= 8'd0;
            nib_lo_q   <= 4'h0;
            half_q     <= 1'b0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            first_q    <= 1'b1;
            len_q      <= '0;
            err_q      <= 1'b0;
            o_data     <= 8'h00;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_err      <= 1'b0;
            o_good_cnt <= '0;
            o_bad_cnt  <= '0;
        end else begin
            if (state_q == S_IDLE) speed_q <= i_speed_sel;

            if (state_q == S_IDLE)
                pre_cnt_q <= 8'd1;
            else if (state_q == S_PRE && is_pre && pre_cnt_q != 8'hFF)
                pre_cnt_q <= pre_cnt_q + 8'd1;

            // Per-frame state is cleared whenever we are outside DATA, so entry is always clean.
            if (state_q != S_DATA) begin
                half_q     <= 1'b0;
                hold_vld_q <= 1'b0;
                first_q    <= 1'b1;
                len_q      <= '0;
                err_q      <= 1'b0;
            end else if (i_rxdv) begin
                if (i_rxer) err_q <= 1'b1;
                if (!speed_q && !half_q) begin
                    nib_lo_q <= i_rxd[3:0];
                    half_q   <= 1'b1;
                end
                if (byte_done) begin
                    half_q     <= 1'b0;
                    hold_q     <= byte_val;
                    hold_vld_q <= 1'b1;
                    len_q      <= len_q + 1'b1;
                end
                if (emit) first_q <= 1'b0;
            end

            o_valid <= emit;
            if (emit) o_data <= hold_q;
            o_sof <= emit && first_q;
            o_eof <= emit && emit_eof;
            o_err <= emit && emit_eof && emit_err;

            if (good_inc && o_good_cnt != '1) o_good_cnt <= o_good_cnt + 1'b1;
            if (bad_inc && o_bad_cnt != '1)   o_bad_cnt  <= o_bad_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rgmii_rx_frame_parser.sv
// Directed bench for rgmii_rx_frame_parser: scoreboard of expected output beats plus counter checks.
module tb_rgmii_rx_frame_parser;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst_n;
    logic        speed_sel;
    logic [7:0]  rxd;
    logic        rxdv;
    logic        rxer;
    logic        sat_phase;

    logic [7:0]  o_data;
    logic        o_valid, o_sof, o_eof, o_err;
    logic [15:0] o_good_cnt, o_bad_cnt;

    logic [7:0]  s_data;
    logic        s_valid, s_sof, s_eof, s_err;
    logic [2:0]  s_good_cnt, s_bad_cnt;

`ifdef RGMII_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    rgmii_rx_frame_parser dut (
        .clk(clk), .I_rst_n(rst_n), .i_speed_sel(speed_sel), .i_rxd(rxd),
        .i_rxdv(rxdv & ~sat_phase), .i_rxer(rxer),
        .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_err(o_err),
        .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
    );

    // Small-counter instance used only to exercise counter saturation quickly.
    rgmii_rx_frame_parser #(.MIN_LEN(4), .MAX_LEN(6), .PRE_MIN(1), .CNT_W(3)) dut_sat (
        .clk(clk), .I_rst_n(rst_n), .i_speed_sel(speed_sel), .i_rxd(rxd),
        .i_rxdv(rxdv & sat_phase), .i_rxer(rxer),
        .o_data(s_data), .o_valid(s_valid), .o_sof(s_sof), .o_eof(s_eof), .o_err(s_err),
        .o_good_cnt(s_good_cnt), .o_bad_cnt(s_bad_cnt)
    );

    logic [10:0] exp_q[$];
    logic [7:0]  frm[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int mon_gap  = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: every o_valid beat pops one expected {data, sof, eof, err}.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (o_valid) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("beat", 32'({o_data, o_sof, o_eof, o_err}), 32'(exp_q.pop_front()));
            if (mon_gap != 0 && !o_sof && !o_eof) chk("beat_gap", 32'(cyc - last_cyc), 32'(mon_gap));
            last_cyc = cyc;
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Payload 0,1,2,... followed by a little-endian FCS; optionally corrupt one FCS bit.
    task automatic build_frame(input int n_total, input bit bad_fcs);
        logic [31:0] c;
        logic [31:0] fcs;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n_total - 4; i++) begin
            frm.push_back(8'(i));
            c = crc_upd(c, 8'(i));
        end
        fcs = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (bad_fcs) frm[n_total-1] = frm[n_total-1] ^ 8'h01;
    endtask

    task automatic expect_frame(input int n_emit, input bit err);
        for (int i = 0; i < n_emit; i++)
            exp_q.push_back({frm[i], 1'(i == 0), 1'(i == n_emit - 1), 1'(err && (i == n_emit - 1))});
    endtask

    task automatic put(input logic [7:0] d, input logic er);
        @(negedge clk);
        rxd  = d;
        rxdv = 1'b1;
        rxer = er;
    endtask

    task automatic end_dv(input int gap);
        @(negedge clk);
        rxdv = 1'b0;
        rxd  = 8'h00;
        rxer = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drive_frame(input bit gig, input int npre, input int nbytes, input int rxer_at,
                               input bit flip_speed, input bit odd_nib, input int gap);
        speed_sel = gig;
        mon_gap   = gig ? 1 : 2;
        for (int i = 0; i < npre; i++) put(gig ? 8'h55 : 8'h05, 1'b0);
        put(gig ? 8'hD5 : 8'h0D, 1'b0);
        if (flip_speed) speed_sel = ~gig;
        for (int i = 0; i < nbytes; i++) begin
            if (gig) begin
                put(frm[i], 1'(i == rxer_at));
            end else begin
                put({4'h0, frm[i][3:0]}, 1'(i == rxer_at));
                put({4'h0, frm[i][7:4]}, 1'(i == rxer_at));
            end
        end
        if (odd_nib) put(8'h0A, 1'b0);
        end_dv(gap);
        speed_sel = gig;
    endtask

    task automatic check_after(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_good"}, 32'(o_good_cnt), 32'(exp_good));
        chk({tag, "_bad"}, 32'(o_bad_cnt), 32'(exp_bad));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_data"}, 32'(o_data), 32'd0);
        chk({tag, "_marks"}, 32'({o_sof, o_eof, o_err}), 32'd0);
        chk({tag, "_good"}, 32'(o_good_cnt), 32'd0);
        chk({tag, "_bad"}, 32'(o_bad_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; speed_sel = 1'b1; rxd = 8'h00; rxdv = 1'b0; rxer = 1'b0; sat_phase = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Gigabit good frame
        build_frame(64, 1'b0);
        expect_frame(64, 1'b0); exp_good++;
        drive_frame(1'b1, 7, 64, -1, 1'b0, 1'b0, 3);
        check_after("gig_good");

        // Nibble-mode good frame; speed select toggled mid-frame must be ignored
        expect_frame(64, 1'b0); exp_good++;
        drive_frame(1'b0, 15, 64, -1, 1'b1, 1'b0, 3);
        check_after("nib_good");

        // Runt
        build_frame(40, 1'b0);
        expect_frame(40, 1'b1); exp_bad++;
        drive_frame(1'b1, 7, 40, -1, 1'b0, 1'b0, 3);
        check_after("runt");

        // rxer for one cycle at byte 20
        build_frame(64, 1'b0);
        expect_frame(64, 1'b1); exp_bad++;
        drive_frame(1'b1, 7, 64, 20, 1'b0, 1'b0, 3);
        check_after("rxer");

        // Bad preamble byte, then a frame starting straight at SFD: both dropped silently
        speed_sel = 1'b1;
        put(8'h55, 1'b0); put(8'h55, 1'b0); put(8'h57, 1'b0);
        for (int i = 0; i < 20; i++) put(frm[i], 1'b0);
        end_dv(2);
        put(8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) put(frm[i], 1'b0);
        end_dv(2);
        check_after("bad_pre");

        // Corrupted FCS: only flagged when the CRC checker is built in
        build_frame(64, 1'b1);
        expect_frame(64, FCS_EN);
        if (FCS_EN) exp_bad++; else exp_good++;
        drive_frame(1'b1, 7, 64, -1, 1'b0, 1'b0, 3);
        check_after("fcs_flip");

        // Nibble mode ending on a half byte
        build_frame(64, 1'b0);
        expect_frame(64, 1'b1); exp_bad++;
        drive_frame(1'b0, 14, 64, -1, 1'b0, 1'b1, 3);
        check_after("odd_nib");

        // SFD then immediate end: no output, bad count only
        exp_bad++;
        drive_frame(1'b1, 7, 0, -1, 1'b0, 1'b0, 3);
        check_after("zero_len");

        // Oversize: cut at byte 1518, the rest is dropped
        build_frame(1600, 1'b0);
        expect_frame(1518, 1'b1); exp_bad++;
        drive_frame(1'b1, 7, 1600, -1, 1'b0, 1'b0, 3);
        check_after("oversize");

        // Two frames separated by a single idle cycle
        build_frame(64, 1'b0);
        expect_frame(64, 1'b0); expect_frame(64, 1'b0); exp_good += 2;
        drive_frame(1'b1, 7, 64, -1, 1'b0, 1'b0, 1);
        drive_frame(1'b1, 7, 64, -1, 1'b0, 1'b0, 3);
        check_after("b2b");

        // Reset at byte 30: bytes 0..28 already emitted, no eof, everything cleared
        for (int i = 0; i < 29; i++) exp_q.push_back({frm[i], 1'(i == 0), 1'b0, 1'b0});
        speed_sel = 1'b1;
        for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
        put(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) put(frm[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0; rxdv = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("mid_reset");
        chk("mid_reset_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_good = 0; exp_bad = 0;
        expect_frame(64, 1'b0); exp_good++;
        drive_frame(1'b1, 7, 64, -1, 1'b0, 1'b0, 3);
        check_after("after_reset");

        // Saturation on the 3-bit counter instance
        sat_phase = 1'b1;
        build_frame(6, 1'b0);
        for (int n = 0; n < 9; n++) begin
            drive_frame(1'b1, 1, 6, -1, 1'b0, 1'b0, 2);
            if (n == 6) chk("sat_good_reach", 32'(s_good_cnt), 32'd7);
        end
        chk("sat_good_hold", 32'(s_good_cnt), 32'd7);
        chk("sat_bad_zero", 32'(s_bad_cnt), 32'd0);
        frm.delete(); frm.push_back(8'hAA); frm.push_back(8'hBB);
        for (int n = 0; n < 9; n++) drive_frame(1'b1, 1, 2, -1, 1'b0, 1'b0, 2);
        repeat (2) @(negedge clk);
        chk("sat_bad_hold", 32'(s_bad_cnt), 32'd7);
        chk("sat_good_kept", 32'(s_good_cnt), 32'd7);
        chk("main_untouched", 32'(o_good_cnt), 32'(exp_good));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_frame_parser.md
Name: rgmii_rx_frame_parser

Overview:
- Receive-side frame parser for the RGMII test path.
- Consumes the per-cycle byte/nibble stream recovered by the IDDR stage (data plus rx_dv) in the receive clock domain.
- Strips preamble/SFD, assembles bytes in gigabit or 10/100 nibble mode, and emits a framed byte stream with start, end and error marks.
- Keeps good/bad frame counters for board bring-up.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS).
- MAX_LEN, 1518, maximum legal frame length in bytes.
- PRE_MIN, 1, minimum count of 0x55 preamble bytes (or nibble-pairs) before SFD.
- CNT_W, 16, width of frame counters and the internal length counter.

Ports:
- clk  input  1  receive clock (RGMII rx clock domain); all logic on the rising edge.
- I_rst_n  input  1  asynchronous active-low reset.
- i_speed_sel  input  1  1 = gigabit, one byte per cycle; 0 = nibble mode, i_rxd[3:0] per cycle, low nibble first.
- i_rxd  input  8  receive data from the IDDR stage.
- i_rxdv  input  1  receive data valid.
- i_rxer  input  1  receive error, qualified by i_rxdv.
- o_data  output  8  frame byte (DA first, FCS included).
- o_valid  output  1  o_data valid.
- o_sof  output  1  first byte of frame; coincides with o_valid.
- o_eof  output  1  last byte of frame; coincides with o_valid.
- o_err  output  1  frame bad; valid only with o_eof.
- o_good_cnt  output  CNT_W  frames ended without error; saturating.
- o_bad_cnt  output  CNT_W  frames ended with error; saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; hold buffer empty.
- Speed latch: i_speed_sel is latched only in IDLE; changes mid-frame are ignored until the next IDLE.
- IDLE:
  - i_rxdv=1 with byte 0x55 (nibble mode: nibble 0x5) goes to PREAMBLE with the preamble count set to 1.
  - i_rxdv=1 with any other value goes to DROP.
- PREAMBLE:
  - Each 0x55 increments the count, saturating.
  - 0xD5 with count>=PRE_MIN goes to DATA.
  - 0xD5 with count<PRE_MIN, or any other value, goes to DROP.
  - i_rxdv=0 goes to IDLE.
  - No output and no counter change on any of these exits.
- Nibble-mode SFD hunt is nibble-by-nibble: the SFD is 0x5 followed by 0xD, and the next nibble is the low nibble of byte 0. This tolerates an odd number of preamble nibbles.
- DATA:
  - Bytes pass through a one-byte hold register, so o_eof marks the true last byte.
  - A byte is emitted (o_valid=1) on the cycle after the next byte completes, or on the cycle after i_rxdv falls (final byte, o_eof=1).
  - Latency from byte-complete to o_valid in gigabit mode: 2 cycles.
  - o_sof=1 on the first emitted byte of each frame.
  - A length counter counts bytes.
- Error sources, sticky per frame:
  - i_rxer=1 while i_rxdv=1 in DATA.
  - Length < MIN_LEN at end of frame.
  - Nibble mode: i_rxdv falls with half a byte assembled. The partial nibble is discarded; the held byte is emitted with o_eof=1 and o_err=1.
  - The FCS check when enabled (see Optional Feature).
- Oversize: when byte MAX_LEN+1 completes, the held byte (byte MAX_LEN) is emitted with o_eof=1 and o_err=1, and the state goes to DROP.
- A frame that ends with zero data bytes after the SFD emits nothing but increments o_bad_cnt.
- DROP: ignores input until i_rxdv=0, then goes to IDLE. No output.
- Counters: on each o_eof, o_good_cnt increments if o_err=0, otherwise o_bad_cnt increments. Both saturate at all-ones.
- i_rxdv deasserted for one cycle and then reasserted: the current frame ends; the next cycle is evaluated from IDLE.
- Reset mid-frame: all state and outputs clear immediately; a partial frame produces no o_eof.

Optional Feature:
- Macro: RGMII_RX_FCS_CHECK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every DATA byte, FCS included.
  - Residue != 0xC704DD7B at end of frame sets o_err on the o_eof byte.
  - No added latency.
- Undefined: no CRC logic; FCS bytes pass through unchecked; o_err reflects only length, rxer and alignment errors.

Test Plan:
- Gigabit frame: 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, valid 4-byte FCS -> 64 o_valid beats; o_sof on byte 0x00; o_eof on the last FCS byte; o_err=0; o_good_cnt=1.
- Same frame in nibble mode (i_speed_sel=0), 15 preamble nibbles then 0xD -> identical o_data sequence; o_valid every 2nd cycle; o_good_cnt=1.
- Runt: 40-byte frame -> o_eof with o_err=1; o_bad_cnt=1. Oversize: 1600-byte frame -> o_eof on byte 1518 with o_err=1; no further o_valid until i_rxdv falls.
- i_rxer=1 for one cycle at byte 20 of a 64-byte frame -> o_err=1 at o_eof. Bad preamble byte 0x57 -> no output, counters unchanged.
- With RGMII_RX_FCS_CHECK_EN: flip one FCS bit -> o_err=1, o_bad_cnt increments. Without the macro: same stimulus -> o_err=0.
- I_rst_n low at byte 30 of a frame -> all outputs 0 next edge; no o_eof; the next full frame parses normally. Counter saturation: preload to all-ones -> stays all-ones.
